key_debounce: RTL

//  - Conditions raw active-low DE10-Nano push-buttons before they reach top-level LED/control logic.
//  - Per key: 2-flop synchronizer, consecutive-stable counter, debounced level, 1-cycle press/release strobes.
//  - Sits directly upstream of the board top's KEY consumers; replaces direct use of raw KEY pins.

---
 rtl/key_debounce.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// ============================================================================
//  Module      : key_debounce
//  Description : Per-key synchronizer, consecutive-stable debouncer and
//                1-cycle press/release strobes for active-low push-buttons.
//                Optional auto-repeat on held keys: define KEY_AUTOREPEAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n_raw,
  output logic [N_KEYS-1:0] key_n_db,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int               REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               REP_W     = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  logic [N_KEYS-1:0] s1_q;
  logic [N_KEYS-1:0] s2_q;

  // Two-flop synchronizer; idle level (released) is 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= key_n_raw;
      s2_q <= s1_q;
    end
  end

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      db_state_e        state;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             db_q;
      logic             db_d;
      logic             press_q;
      logic             press_d;
      logic             release_q;
      logic             release_d;
      logic             press_evt;
      logic             release_evt;

      always_comb begin
        state       = (s2_q[gi] == db_q) ? STABLE : PENDING;
        cnt_d       = '0;
        db_d        = db_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        if (state == PENDING) begin
          if (cnt_q == CNT_TERM) begin
            db_d        = s2_q[gi];
            press_evt   = ~s2_q[gi];
            release_evt = s2_q[gi];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q     <= '0;
          db_q      <= 1'b1;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          db_q      <= db_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

`ifdef KEY_AUTOREPEAT_EN
      logic [REP_W-1:0] rep_cnt_q;
      logic [REP_W-1:0] rep_cnt_d;
      logic             rep_first_q;
      logic             rep_first_d;
      logic             rep_fire;

      // Counter idles at 0 while released; a release edge suppresses a
      // coinciding repeat so press and release never share a cycle.
      always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (db_q || release_evt) begin
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
        end else if (rep_cnt_q == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
          rep_fire    = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rep_cnt_q   <= '0;
          rep_first_q <= 1'b1;
        end else begin
          rep_cnt_q   <= rep_cnt_d;
          rep_first_q <= rep_first_d;
        end
      end

      assign press_d = press_evt | rep_fire;
`else
      assign press_d = press_evt;
`endif
      assign release_d = release_evt;

      assign key_n_db[gi]    = db_q;
      assign key_press[gi]   = press_q;
      assign key_release[gi] = release_q;
    end
  endgenerate

endmodule

`default_nettype wire
